// File: rtl/vga_timing_driver.sv
// 640x480@60 VGA raster timing: sync, pixel request, blanked RGB.
// Outputs decode straight from the h/v counters.
module vga_timing_driver #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_DISP   = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_TOTAL  = 800,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_DISP   = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_TOTAL  = 525,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        driver_clk,
  input  logic        sys_rst_n,
  input  logic [29:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        vga_en,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [29:0] vga_rgb,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST =
    10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW =
    10'(H_SYNC);
  localparam logic [9:0] V_SW =
    10'(V_SYNC);
  localparam logic [9:0] H_ACT_S =
    10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_E =
    10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] H_REQ_S =
    10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_E =
    10'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [9:0] V_ACT_S =
    10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_E =
    10'(V_SYNC + V_BACK + V_DISP);

  if (H_SYNC + H_BACK + H_DISP + H_FRONT
      != H_TOTAL) begin : g_h_chk
    $error("horizontal totals disagree");
  end
  if (V_SYNC + V_BACK + V_DISP + V_FRONT
      != V_TOTAL) begin : g_v_chk
    $error("vertical totals disagree");
  end

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_wrap;
  logic       v_wrap;
  logic       v_act;
  logic       h_act;
  logic       h_req;

  assign h_wrap = (cnt_h == H_LAST);
  assign v_wrap = (cnt_v == V_LAST);

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
    end else if (h_wrap) begin
      cnt_h <= '0;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_v <= '0;
    end else if (h_wrap) begin
      if (v_wrap) begin
        cnt_v <= '0;
      end else begin
        cnt_v <= cnt_v + 10'd1;
      end
    end
  end

  assign v_act = (cnt_v >= V_ACT_S) &&
                 (cnt_v <  V_ACT_E);
  assign h_act = (cnt_h >= H_ACT_S) &&
                 (cnt_h <  H_ACT_E);
  // Request leads the active window by one
  // cycle to absorb the pattern register.
  assign h_req = (cnt_h >= H_REQ_S) &&
                 (cnt_h <  H_REQ_E);

  assign vga_hs = (cnt_h < H_SW) ?
                  SYNC_POL : ~SYNC_POL;
  assign vga_vs = (cnt_v < V_SW) ?
                  SYNC_POL : ~SYNC_POL;

  assign vga_en   = v_act & h_act;
  assign data_req = v_act & h_req;

  assign pixel_xpos = data_req ?
                      (cnt_h - H_REQ_S) : '0;
  assign pixel_ypos = data_req ?
                      (cnt_v - V_ACT_S) : '0;

  assign vga_rgb = vga_en ? pixel_data : '0;

  assign frame_start = (cnt_h == '0) &&
                       (cnt_v == '0);

endmodule
